msx_joyport_ctrl: RTL and testbench

- Controller that shares MSX joystick port A between the MiST digital joystick and the PS/2 mouse.
- Sequences the MSX mouse nibble protocol, driven by strobe-pin toggles from the PSG port-B register.
- Sits between user_io (joystick_0, mouse_x/y/flags/strobe) and the emsx_top pJoyA/pStra pins.
- Top level handles pin reordering and tri-state conversion; this block outputs plain pin levels.

---
 rtl/msx_joyport_ctrl.sv | 129 ++++++++++++
 tb/tb_msx_joyport_ctrl.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/msx_joyport_ctrl.sv
// Shares MSX joystick port A between the digital joystick and a PS/2 mouse speaking the MSX nibble protocol.
// Define JOYPORT_ACCUM_EN to accumulate mouse deltas with saturation; otherwise each packet overwrites the count.
module msx_joyport_ctrl #(
  parameter int unsigned TIMEOUT = 100000,
  parameter int unsigned SAT_MAX = 127
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic [5:0] joy,
  input  logic       mouse_strobe,
  input  logic [8:0] mouse_x,
  input  logic [8:0] mouse_y,
  input  logic [1:0] mouse_btn,
  input  logic       msx_str,
  output logic [5:0] port_out,
  output logic       mouse_mode
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
`ifdef JOYPORT_ACCUM_EN
  localparam bit ACCUM = 1'b1;
`else
  localparam bit ACCUM = 1'b0;
`endif

  typedef enum logic {S_JOY, S_MOUSE} mode_t;

  mode_t          mode, mode_n;
  logic           str_d;
  logic [1:0]     phase;
  logic [TW-1:0]  timer;
  logic [7:0]     acc_x, acc_y;
  logic [7:0]     latch_x, latch_y;
  logic           edge_c;
  logic [9:0]     dx_c, dy_c;
  logic [3:0]     nib_c;

  // New count from an old count and a 10-bit delta: clamped sum, or plain low byte of the delta
  function automatic logic [7:0] upd(input logic [7:0] a, input logic [9:0] d);
    logic signed [9:0] s;
    logic signed [9:0] lim;
    lim = $signed(10'(SAT_MAX));
    s   = $signed({{2{a[7]}}, a}) + $signed(d);
    if (!ACCUM)         return d[7:0];
    else if (s > lim)   return 8'(lim);
    else if (s < -lim)  return 8'(-lim);
    else                return s[7:0];
  endfunction

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) mode <= S_JOY;
    else       mode <= mode_n;
  end

  always_comb begin
    mode_n = mode;
    edge_c = msx_str ^ str_d;
    // MSX X axis runs opposite to the PS/2 one
    dx_c   = 10'd0 - {mouse_x[8], mouse_x};
    dy_c   = {mouse_y[8], mouse_y};
    nib_c  = 4'hF;
    case (mode)
      S_JOY:   if (mouse_strobe) mode_n = S_MOUSE;
      S_MOUSE: if ((|joy) && !mouse_strobe) mode_n = S_JOY;
      default: mode_n = S_JOY;
    endcase
    case (phase)
      2'd0: nib_c = acc_x[7:4];
      2'd1: nib_c = latch_x[3:0];
      2'd2: nib_c = latch_y[7:4];
      2'd3: nib_c = latch_y[3:0];
      default: nib_c = 4'hF;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      port_out   <= 6'h3F;
      mouse_mode <= 1'b0;
      str_d      <= 1'b0;
      phase      <= 2'd0;
      timer      <= '0;
      acc_x      <= 8'd0;
      acc_y      <= 8'd0;
      latch_x    <= 8'd0;
      latch_y    <= 8'd0;
    end else begin
      str_d      <= msx_str;
      mouse_mode <= (mode_n == S_MOUSE);
      if (mode_n == S_JOY) begin
        port_out <= msx_str ? 6'h3F : ~joy;
        phase    <= 2'd0;
        timer    <= '0;
        acc_x    <= 8'd0;
        acc_y    <= 8'd0;
        latch_x  <= 8'd0;
        latch_y  <= 8'd0;
      end else begin
        port_out[5:4] <= ~mouse_btn;
        if (edge_c) begin
          timer         <= TW'(TIMEOUT);
          phase         <= phase + 2'd1;
          port_out[3:0] <= nib_c;
          if (phase == 2'd0) begin
            // Snapshot the count; a packet arriving on this edge starts the next count
            latch_x <= acc_x;
            latch_y <= acc_y;
            acc_x   <= mouse_strobe ? upd(8'd0, dx_c) : 8'd0;
            acc_y   <= mouse_strobe ? upd(8'd0, dy_c) : 8'd0;
          end else if (mouse_strobe) begin
            acc_x <= upd(acc_x, dx_c);
            acc_y <= upd(acc_y, dy_c);
          end
        end else begin
          if (mode == S_JOY) port_out[3:0] <= 4'hF;
          if (mouse_strobe) begin
            acc_x <= upd(acc_x, dx_c);
            acc_y <= upd(acc_y, dy_c);
          end
          if (timer != '0) begin
            timer <= timer - TW'(1);
            if (timer == TW'(1)) phase <= 2'd0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_msx_joyport_ctrl.sv
// Directed bench for msx_joyport_ctrl: vector table for joystick and mouse nibble reads, plus timeout, mode-conflict and reset sequences.
module tb_msx_joyport_ctrl;

  localparam int unsigned TO = 200;

  logic       clk_sys = 1'b0;
  logic       reset;
  logic [5:0] joy;
  logic       mouse_strobe;
  logic [8:0] mouse_x, mouse_y;
  logic [1:0] mouse_btn;
  logic       msx_str;
  logic [5:0] port_out;
  logic       mouse_mode;

  int checks = 0;
  int fails  = 0;

  msx_joyport_ctrl #(.TIMEOUT(TO), .SAT_MAX(127)) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .joy          (joy),
    .mouse_strobe (mouse_strobe),
    .mouse_x      (mouse_x),
    .mouse_y      (mouse_y),
    .mouse_btn    (mouse_btn),
    .msx_str      (msx_str),
    .port_out     (port_out),
    .mouse_mode   (mouse_mode)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [5:0] joy;
    logic       stb;
    logic [8:0] mx;
    logic [8:0] my;
    logic [1:0] btn;
    logic       str;
    int         gap;
    logic [5:0] ep;
    logic       em;
  } vec_t;

  vec_t tv[15];

`ifdef JOYPORT_ACCUM_EN
  localparam logic [5:0] E11 = 6'h37, E12 = 6'h3F, E13 = 6'h38, E14 = 6'h31;
`else
  localparam logic [5:0] E11 = 6'h36, E12 = 6'h34, E13 = 6'h33, E14 = 6'h38;
`endif

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string name, input logic [5:0] ep, input logic em);
    checks++;
    if (port_out !== ep) begin
      fails++;
      $display("FAIL %s port_out: got %h expected %h", name, port_out, ep);
    end
    checks++;
    if (mouse_mode !== em) begin
      fails++;
      $display("FAIL %s mouse_mode: got %b expected %b", name, mouse_mode, em);
    end
  endtask

  initial begin
    tv[0]  = '{6'b010001, 1'b0, 9'h000, 9'h000, 2'b00, 1'b0, 0,   6'b101110, 1'b0};
    tv[1]  = '{6'b010001, 1'b0, 9'h000, 9'h000, 2'b00, 1'b1, 0,   6'h3F, 1'b0};
    tv[2]  = '{6'b000000, 1'b0, 9'h000, 9'h000, 2'b00, 1'b1, 0,   6'h3F, 1'b0};
    tv[3]  = '{6'b000000, 1'b1, 9'h005, 9'h003, 2'b01, 1'b1, 2,   6'h2F, 1'b1};
    tv[4]  = '{6'b000000, 1'b0, 9'h000, 9'h000, 2'b01, 1'b0, 100, 6'h2F, 1'b1};
    tv[5]  = '{6'b000000, 1'b0, 9'h000, 9'h000, 2'b01, 1'b1, 100, 6'h2B, 1'b1};
    tv[6]  = '{6'b000000, 1'b0, 9'h000, 9'h000, 2'b01, 1'b0, 100, 6'h20, 1'b1};
    tv[7]  = '{6'b000000, 1'b0, 9'h000, 9'h000, 2'b01, 1'b1, 2,   6'h23, 1'b1};
    tv[8]  = '{6'b000000, 1'b1, 9'h19C, 9'h138, 2'b00, 1'b1, 2,   6'h33, 1'b1};
    tv[9]  = '{6'b000000, 1'b1, 9'h19C, 9'h138, 2'b00, 1'b1, 2,   6'h33, 1'b1};
    tv[10] = '{6'b000000, 1'b1, 9'h19C, 9'h138, 2'b00, 1'b1, 2,   6'h33, 1'b1};
    tv[11] = '{6'b000000, 1'b0, 9'h000, 9'h000, 2'b00, 1'b0, 100, E11,   1'b1};
    tv[12] = '{6'b000000, 1'b0, 9'h000, 9'h000, 2'b00, 1'b1, 100, E12,   1'b1};
    tv[13] = '{6'b000000, 1'b0, 9'h000, 9'h000, 2'b00, 1'b0, 100, E13,   1'b1};
    tv[14] = '{6'b000000, 1'b0, 9'h000, 9'h000, 2'b00, 1'b1, 100, E14,   1'b1};

    reset = 1'b1; joy = 6'd0; mouse_strobe = 1'b0; mouse_x = 9'd0; mouse_y = 9'd0;
    mouse_btn = 2'b00; msx_str = 1'b0;
    tick();
    check("reset_state", 6'h3F, 1'b0);
    tick();
    reset = 1'b0;
    tick();

    for (int i = 0; i < 15; i++) begin
      joy = tv[i].joy; mouse_strobe = tv[i].stb; mouse_x = tv[i].mx; mouse_y = tv[i].my;
      mouse_btn = tv[i].btn; msx_str = tv[i].str;
      tick();
      mouse_strobe = 1'b0;
      check($sformatf("vec%0d", i), tv[i].ep, tv[i].em);
      repeat (tv[i].gap) tick();
    end

    // Phase returns to 0 once the strobe goes quiet for longer than the timeout
    msx_str = 1'b0; tick(); check("seq_p0_empty", 6'h30, 1'b1);
    repeat (5) tick();
    msx_str = 1'b1; tick(); check("seq_p1_empty", 6'h30, 1'b1);
    mouse_strobe = 1'b1; mouse_x = 9'h1D0; mouse_y = 9'h000; tick(); mouse_strobe = 1'b0;
    repeat (TO + 2) tick();
    msx_str = 1'b0; tick(); check("timeout_p0", 6'h33, 1'b1);
    mouse_strobe = 1'b1; mouse_x = 9'h1DB; tick(); mouse_strobe = 1'b0;
    repeat (TO - 10) tick();
    msx_str = 1'b1; tick(); check("no_timeout_p1", 6'h30, 1'b1);

    // Strobe wins over joystick activity; without it the joystick takes the port
    joy = 6'b000100; mouse_strobe = 1'b1; mouse_x = 9'h000; tick(); mouse_strobe = 1'b0;
    check("conflict_stays_mouse", 6'h30, 1'b1);
    msx_str = 1'b0; tick(); check("joy_takes_port", 6'h3B, 1'b0);
    joy = 6'd0; tick(); check("joy_idle", 6'h3F, 1'b0);

    // Asynchronous reset mid-sequence, then a fresh read starts at phase 0
    mouse_strobe = 1'b1; mouse_x = 9'h1EE; tick(); mouse_strobe = 1'b0;
    check("reenter_mouse", 6'h3F, 1'b1);
    repeat (2) tick();
    msx_str = 1'b1; tick(); check("pre_rst_p0", 6'h31, 1'b1);
    repeat (3) tick();
    msx_str = 1'b0; tick(); check("pre_rst_p1", 6'h32, 1'b1);
    #2 reset = 1'b1;
    #1 check("async_reset", 6'h3F, 1'b0);
    repeat (3) tick();
    reset = 1'b0;
    repeat (2) tick();
    check("after_reset", 6'h3F, 1'b0);
    mouse_strobe = 1'b1; mouse_x = 9'h1BB; tick(); mouse_strobe = 1'b0;
    check("post_rst_mouse", 6'h3F, 1'b1);
    repeat (2) tick();
    msx_str = 1'b1; tick(); check("post_rst_p0", 6'h34, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
